bcd_to_binary_seq: RTL and testbench

Sequential BCD-to-binary converter: the inverse of the binary-to-BCD display converter.
- Takes NDIG packed BCD digits plus a sign flag and produces a W-bit two's-complement value.
- Used to turn keypad/switch decimal entry into processor register operands.
- Iterative multiply-by-10 accumulate, one digit per clock, most significant digit first, with a start/done handshake.

---
 rtl/bcd_to_binary_seq.sv | 77 +++++++
 tb/tb_bcd_to_binary_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: iterative BCD-to-two's-complement converter, one digit per clock, MSD first
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   start  : request conversion (accepted only when idle)
//   bcd_in : NDIG packed BCD digits, digit NDIG-1 most significant
//   neg_in : result is negative
//   value  : converted result, held until next completion
//   done   : one-cycle pulse when value/err update
//   busy   : conversion in progress
//   err    : last conversion saw a digit above 9
module bcd_to_binary_seq #(
  parameter int NDIG = 8,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic              neg_in,
  output logic [W-1:0]      value,
  output logic              done,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(NDIG) + 1;
  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;
  state_t            state;
  logic [4*NDIG-1:0] sr;
  logic [W-1:0]      acc;
  logic [CW-1:0]     cnt;
  logic              neg, bad;
  logic [3:0]        d;
  assign d = sr[4*NDIG-1 -: 4];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      bad   <= 1'b0;
      value <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sr    <= bcd_in;
          neg   <= neg_in;
          acc   <= '0;
          cnt   <= '0;
          bad   <= 1'b0;
          busy  <= 1'b1;
          state <= CONV;
        end
        CONV: begin
          // acc*10 + d as two shifts and an add
          acc   <= (acc << 3) + (acc << 1) + W'(d);
          bad   <= bad | (d > 4'd9);
          sr    <= sr << 4;
          cnt   <= cnt + 1'b1;
          state <= (cnt == CW'(NDIG - 1)) ? FINISH : CONV;
        end
        FINISH: begin
          value <= bad ? '0 : (neg ? -acc : acc);
          err   <= bad;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: scoreboard bench for bcd_to_binary_seq with directed hand-computed vectors
module tb_bcd_to_binary_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        neg_in = 1'b0;
  logic [31:0] bcd_in = '0;
  logic [31:0] value;
  logic        done, busy, err;
  int compared = 0;
  int mismatched = 0;
  logic [32:0] q[$];

  bcd_to_binary_seq #(.NDIG(8), .W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in), .neg_in(neg_in),
    .value(value), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 expected no pending conversion");
      end else begin
        logic [32:0] e;
        e = q.pop_front();
        chk("value", value, e[31:0]);
        chk("err", err, e[32]);
      end
    end
  end

  task automatic conv(input logic [31:0] b, input logic n, input logic [31:0] ev, input logic ee, input bit mid);
    int k;
    q.push_back({ee, ev});
    @(negedge clk);
    bcd_in = b;
    neg_in = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcd_in = 32'h00000987;
    neg_in = ~n;
    chk("busy_after_start", busy, 1);
    k = 0;
    while (!done && k < 20) begin
      if (mid && (k == 2 || k == 4)) begin
        start = 1'b1;
        bcd_in = 32'h00000555;
      end
      @(negedge clk);
      start = 1'b0;
      k++;
      if (!done && k < 9) chk("busy_mid", busy, 1);
    end
    chk("latency", k, 9);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_value", value, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    conv(32'h12345678, 1'b0, 32'h00BC614E, 1'b0, 1'b0);
    conv(32'h99999999, 1'b1, 32'hFA0A1F01, 1'b0, 1'b0);
    conv(32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    conv(32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    conv(32'h0000A000, 1'b0, 32'h00000000, 1'b1, 1'b0);
    conv(32'h00000042, 1'b0, 32'h0000002A, 1'b0, 1'b0);
    conv(32'h00000250, 1'b1, 32'hFFFFFF06, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    // start held high: conversions every NDIG+2 clocks
    repeat (3) q.push_back({1'b0, 32'h00000064});
    @(negedge clk);
    bcd_in = 32'h00000100;
    neg_in = 1'b0;
    start = 1'b1;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("first_done_held", done, 1);
    repeat (2) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!done && k < 20);
      chk("throughput_gap", k, 10);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    // reset mid-conversion aborts it
    @(negedge clk);
    bcd_in = 32'h00000777;
    neg_in = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_value", value, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    conv(32'h00009876, 1'b0, 32'h00002694, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
